seven_seg_scanner: RTL and testbench

//  Downstream stage of seven_seg_controller. Takes the 28-bit packed segment word

---
 rtl/seven_seg_scanner.sv | 104 ++++++++++
 tb/tb_seven_seg_scanner.sv | 135 +++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit seven-segment scanner with per-slot blanking and per-frame snapshot.
// Optional macro SEG_BRIGHTNESS_EN adds a 4-bit brightness input that shortens the drive window.
module seven_seg_scanner #(
  parameter int unsigned DIGIT_CYCLES   = 50000,
  parameter int unsigned BLANK_CYCLES   = 8,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [27:0] displ,
`ifdef SEG_BRIGHTNESS_EN
  input  logic [3:0]  bright,
`endif
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam int unsigned TickW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [TickW-1:0] LastTick  = TickW'(DIGIT_CYCLES - 1);
  localparam logic [TickW-1:0] BlankTick = TickW'(BLANK_CYCLES);
  localparam logic [6:0] SegOff = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AnOff  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;

  logic [TickW-1:0] tick_q, tick_d;
  logic [1:0]       dig_q, dig_d;
  logic [27:0]      frame_q, frame_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             fs_q, fs_d;
  logic             snap, drive;
  logic [6:0]       lit_seg;
  logic [3:0]       lit_an;

`ifdef SEG_BRIGHTNESS_EN
  localparam int unsigned Window = DIGIT_CYCLES - BLANK_CYCLES;
  logic [3:0]  bright_q, bright_d;
  logic [31:0] drive_len;
`endif

  always_comb begin
    snap    = (tick_q == '0) && (dig_q == 2'd0);
    tick_d  = tick_q + 1'b1;
    dig_d   = dig_q;
    if (tick_q == LastTick) begin
      tick_d = '0;
      dig_d  = dig_q + 2'd1;
    end
    // Decode from frame_d so the snapshot cycle already sees the new word when there is no blank.
    frame_d = snap ? displ : frame_q;
    drive   = (tick_q >= BlankTick);
`ifdef SEG_BRIGHTNESS_EN
    bright_d  = snap ? bright : bright_q;
    drive_len = (32'(Window) * (32'(bright_d) + 32'd1)) >> 4;
    if ((32'(tick_q) - 32'(BLANK_CYCLES)) >= drive_len) begin
      drive = 1'b0;
    end
`endif
    unique case (dig_q)
      2'd0:    lit_seg = frame_d[6:0];
      2'd1:    lit_seg = frame_d[13:7];
      2'd2:    lit_seg = frame_d[20:14];
      default: lit_seg = frame_d[27:21];
    endcase
    lit_an = 4'b0001 << dig_q;
    if (!drive) begin
      lit_seg = '0;
      lit_an  = '0;
    end
    seg_d = SEG_ACTIVE_LOW ? ~lit_seg : lit_seg;
    an_d  = AN_ACTIVE_LOW  ? ~lit_an  : lit_an;
    fs_d  = snap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q   <= '0;
      dig_q    <= 2'd0;
      frame_q  <= '0;
      seg_q    <= SegOff;
      an_q     <= AnOff;
      fs_q     <= 1'b0;
`ifdef SEG_BRIGHTNESS_EN
      bright_q <= 4'd0;
`endif
    end else begin
      tick_q   <= tick_d;
      dig_q    <= dig_d;
      frame_q  <= frame_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      fs_q     <= fs_d;
`ifdef SEG_BRIGHTNESS_EN
      bright_q <= bright_d;
`endif
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: expected outputs come from a cycle-position model of the frame.
module tb_seven_seg_scanner;

`ifdef SEG_BRIGHTNESS_EN
  localparam int D = 18;
`else
  localparam int D = 8;
`endif
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [27:0] displ = '0;
  logic [3:0]  bright = 4'd15;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_start;

  int tests = 0;
  int fails = 0;
  int k = 0;
  logic [27:0] mframe = '0;
  int mbright = 15;

  seven_seg_scanner #(
    .DIGIT_CYCLES  (D),
    .BLANK_CYCLES  (B),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .displ      (displ),
`ifdef SEG_BRIGHTNESS_EN
    .bright     (bright),
`endif
    .seg        (seg),
    .an         (an),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s k=%0d got %h expected %h", tag, k, got, exp);
    end
  endtask

  // One clock: model predicts the outputs of the coming edge, then they are compared.
  task automatic cycle();
    logic [6:0] es;
    logic [3:0] ea;
    logic       ef;
    int p, slot, off, len;
    es = 7'h7F;
    ea = 4'hF;
    ef = 1'b0;
    if (rst) begin
      k = 0;
    end else begin
      p = k % (4 * D);
      if (p == 0) begin
        mframe = displ;
`ifdef SEG_BRIGHTNESS_EN
        mbright = int'(bright);
`endif
      end
      slot = p / D;
      off  = p % D;
      ef   = (p == 0);
      len  = ((D - B) * (mbright + 1)) / 16;
      if (off >= B && (off - B) < len) begin
        ea = ~(4'b0001 << slot);
        es = ~mframe[7*slot +: 7];
      end
      k++;
    end
    @(posedge clk);
    #1;
    check("seg", seg, es);
    check("an", {3'b0, an}, {3'b0, ea});
    check("frame_start", {6'b0, frame_start}, {6'b0, ef});
    check("an_onehot", {6'b0, ($countones(~an) <= 1)}, 7'd1);
  endtask

  initial begin
    // Reset held for 3 edges.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Single-digit pattern: digit 0 = 3F, others 06.
    displ = {7'h06, 7'h06, 7'h06, 7'h3F};
    rst = 1'b0;
    for (int i = 0; i < 3 * 4 * D; i++) cycle();

    // Tearing: change digit 1 while it is driven; new value appears next frame only.
    while ((k % (4 * D)) != D + B + 1) cycle();
    displ[13:7] = 7'h7F;
    for (int i = 0; i < 5 * D; i++) cycle();

    // Mid-frame reset during digit 2.
    while ((k % (4 * D)) != 2 * D + B + 2) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    displ = 28'h1234567;
    for (int i = 0; i < 8 * D; i++) cycle();

`ifdef SEG_BRIGHTNESS_EN
    bright = 4'd7;
    for (int i = 0; i < 8 * D; i++) cycle();
    bright = 4'd15;
    for (int i = 0; i < 8 * D; i++) cycle();
`endif

    // Random data every cycle, random brightness, occasional resets.
    for (int i = 0; i < 1500; i++) begin
      displ  = 28'($urandom);
`ifdef SEG_BRIGHTNESS_EN
      bright = 4'($urandom_range(15, 0));
`endif
      rst = ($urandom_range(60, 0) == 0);
      cycle();
    end
    rst = 1'b0;
    for (int i = 0; i < 4 * D; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
